priority_dec: RTL and testbench

PRIORITY_DEC -- requirements
Module: priority_dec

---
 rtl/priority_dec.sv | 145 ++++++++++++++
 tb/tb_priority_dec.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/priority_dec.sv
// Frame-based priority decoder: ORs one-hot bit positions over a frame of 1..4 beats and
// holds the result until downstream accepts it. Optional duplicate check: PRIORITY_DEC_DUP_CHK_EN.
module priority_dec (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] in_pos,
    input  logic       in_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_vec,
    output logic [2:0] out_cnt,
    output logic       out_err
);

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // One-hot decode of a 2-bit position.
    function automatic logic [3:0] onehot4(input logic [1:0] pos);
        onehot4 = 4'b0001 << pos;
    endfunction

    state_t      state_r;
    state_t      state_nxt_s;
    logic        in_ready_r;
    logic        out_valid_r;
    logic [3:0]  acc_r;
    logic [2:0]  cnt_r;
    logic [3:0]  out_vec_r;
    logic [2:0]  out_cnt_r;

    logic        accept_s;
    logic        close_s;
    logic [3:0]  bit_s;
    logic [3:0]  acc_nxt_s;
    logic [2:0]  cnt_nxt_s;

    // Beat acceptance, accumulator update and frame-close detection.
    always_comb begin
        bit_s     = onehot4(in_pos);
        accept_s  = in_valid && (state_r == COLLECT);
        acc_nxt_s = acc_r | bit_s;
        cnt_nxt_s = cnt_r + 3'd1;
        if (accept_s) begin
            close_s = in_last || (cnt_nxt_s == 3'd4);
        end else begin
            close_s = 1'b0;
        end
    end

    // Next-state logic: close a frame into HOLD, release on the output handshake.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            COLLECT: begin
                if (close_s) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = COLLECT;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt_s = COLLECT;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = COLLECT;
        endcase
    end

    // State register with handshake flags registered alongside so they never see in_valid combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= COLLECT;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            in_ready_r  <= (state_nxt_s == COLLECT);
            out_valid_r <= (state_nxt_s == HOLD);
        end
    end

    // Accumulator/counter and output capture; outputs only change at frame close.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r     <= 4'd0;
            cnt_r     <= 3'd0;
            out_vec_r <= 4'd0;
            out_cnt_r <= 3'd0;
        end else if (accept_s) begin
            if (close_s) begin
                acc_r     <= 4'd0;
                cnt_r     <= 3'd0;
                out_vec_r <= acc_nxt_s;
                out_cnt_r <= cnt_nxt_s;
            end else begin
                acc_r     <= acc_nxt_s;
                cnt_r     <= cnt_nxt_s;
            end
        end
    end

`ifdef PRIORITY_DEC_DUP_CHK_EN
    logic dup_r;
    logic dup_nxt_s;
    logic out_err_r;

    // Sticky duplicate flag including the current beat.
    always_comb begin
        dup_nxt_s = dup_r | (|(acc_r & bit_s));
    end

    // Duplicate flag clears with the accumulator and is captured at frame close.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dup_r     <= 1'b0;
            out_err_r <= 1'b0;
        end else if (accept_s) begin
            if (close_s) begin
                dup_r     <= 1'b0;
                out_err_r <= dup_nxt_s;
            end else begin
                dup_r     <= dup_nxt_s;
            end
        end
    end

    assign out_err = out_err_r;
`else
    assign out_err = 1'b0;
`endif

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_vec   = out_vec_r;
    assign out_cnt   = out_cnt_r;

endmodule

// File: tb/tb_priority_dec.sv
// Scoreboard bench for priority_dec: a bench-side frame model pushes expected frames when
// beats are accepted; they are popped and compared when the output handshake happens.
module tb_priority_dec;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_pos;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_vec;
    logic [2:0] out_cnt;
    logic       out_err;

    typedef struct packed {
        logic [3:0] vec;
        logic [2:0] cnt;
        logic       err;
    } frame_t;

    frame_t     exp_q[$];
    int         checks_cnt;
    int         errors_cnt;
    logic [3:0] m_acc;
    logic [2:0] m_cnt;
    logic       m_dup;

    priority_dec dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pos   (in_pos),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_vec  (out_vec),
        .out_cnt  (out_cnt),
        .out_err  (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_acc = 4'd0;
        m_cnt = 3'd0;
        m_dup = 1'b0;
    endtask

    // Drive one beat and wait (bounded) for it to be accepted; model it on acceptance.
    task automatic beat(input logic [1:0] pos, input logic last);
        frame_t     f;
        logic [3:0] b;
        int         n;
        in_valid = 1'b1;
        in_pos   = pos;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("beat_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        b = 4'b0001 << pos;
        if ((m_acc & b) != 4'd0) m_dup = 1'b1;
        m_acc = m_acc | b;
        m_cnt = m_cnt + 3'd1;
        if (last || m_cnt == 3'd4) begin
            f.vec = m_acc;
            f.cnt = m_cnt;
`ifdef PRIORITY_DEC_DUP_CHK_EN
            f.err = m_dup;
`else
            f.err = 1'b0;
`endif
            exp_q.push_back(f);
            model_clear();
            chk("close_valid", {31'd0, out_valid}, 32'd1);
            chk("close_ready", {31'd0, in_ready}, 32'd0);
        end
    endtask

    // Accept one frame from the DUT and compare against the scoreboard head.
    task automatic drain();
        frame_t f;
        int     n;
        out_ready = 1'b1;
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_valid) begin
            chk("drain_timeout", 32'd0, 32'd1);
            out_ready = 1'b0;
            return;
        end
        if (exp_q.size() == 0) begin
            chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
            f = exp_q.pop_front();
            chk("out_vec", {28'd0, out_vec}, {28'd0, f.vec});
            chk("out_cnt", {29'd0, out_cnt}, {29'd0, f.cnt});
            chk("out_err", {31'd0, out_err}, {31'd0, f.err});
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_hs_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [3:0] held_vec;
        logic [2:0] held_cnt;
        logic       held_err;
        checks_cnt = 0;
        errors_cnt = 0;
        model_clear();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pos    = 2'd0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_vec", {28'd0, out_vec}, 32'd0);
        chk("rst_cnt", {29'd0, out_cnt}, 32'd0);
        chk("rst_err", {31'd0, out_err}, 32'd0);
        rst = 1'b0;

        // Single beat, then pos 0,3 frame, then 4-beat auto-close with a duplicate.
        beat(2'd2, 1'b1);
        drain();
        beat(2'd0, 1'b0);
        beat(2'd3, 1'b1);
        drain();
        beat(2'd1, 1'b0);
        beat(2'd1, 1'b0);
        beat(2'd2, 1'b0);
        beat(2'd0, 1'b0);
        drain();

        // Backpressure while in_valid stays high: nothing moves.
        beat(2'd3, 1'b0);
        beat(2'd0, 1'b1);
        held_vec = out_vec;
        held_cnt = out_cnt;
        held_err = out_err;
        in_valid = 1'b1;
        in_pos   = 2'd1;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_vec", {28'd0, out_vec}, {28'd0, held_vec});
            chk("bp_cnt", {29'd0, out_cnt}, {29'd0, held_cnt});
            chk("bp_err", {31'd0, out_err}, {31'd0, held_err});
        end
        in_valid = 1'b0;
        drain();

        // Reset mid-frame discards the partial frame.
        beat(2'd0, 1'b0);
        beat(2'd1, 1'b0);
        rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        rst = 1'b0;
        beat(2'd3, 1'b1);
        drain();

        // Reset during HOLD drops the pending frame.
        beat(2'd2, 1'b1);
        rst = 1'b1;
        void'(exp_q.pop_back());
        #2;
        chk("holdrst_valid", {31'd0, out_valid}, 32'd0);
        chk("holdrst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Random frames.
        for (int f = 0; f < 20; f++) begin
            for (int b = 0; b < 4; b++) begin
                logic lst;
                lst = ($urandom_range(0, 2) == 0);
                beat(2'($urandom_range(0, 3)), lst);
                if (lst) break;
            end
            drain();
        end

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
